// File: rtl/pi_framestore_arbiter.sv
// rtl/pi_framestore_arbiter.sv - single-port framestore arbiter: buffered capture writes vs. capped-priority display reads
module pi_framestore_arbiter #(
    parameter int ADDR_W      = 19,
    parameter int DATA_W      = 16,
    parameter int WFIFO_DEPTH = 4,
    parameter int MEM_LAT     = 2,
    parameter int MAX_RD_RUN  = 4
) (
    input  logic                           pixelClockX6,
    input  logic                           nReset,
    input  logic                           frame_start_flag,
    input  logic                           wr_valid,
    input  logic [ADDR_W-1:0]              wr_addr,
    input  logic [DATA_W-1:0]              wr_data,
    input  logic                           rd_req,
    input  logic [ADDR_W-1:0]              rd_addr,
    output logic                           rd_gnt,
    output logic                           rd_valid,
    output logic [DATA_W-1:0]              rd_data,
    output logic                           mem_en,
    output logic                           mem_we,
    output logic [ADDR_W-1:0]              mem_addr,
    output logic [DATA_W-1:0]              mem_wdata,
    input  logic [DATA_W-1:0]              mem_rdata,
    output logic [$clog2(WFIFO_DEPTH):0]   wfifo_level,
    output logic                           wr_overflow,
    output logic [7:0]                     wr_drop_count
);
    localparam int PTR_W = $clog2(WFIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam int RUN_W = $clog2(MAX_RD_RUN + 1);

    typedef enum logic [1:0] {IDLE = 2'd0, RD = 2'd1, WR = 2'd2} grantState_t;

    grantState_t state, nextState;
    logic [RUN_W-1:0] runCnt, runNext;
    logic [PTR_W-1:0] wrPtr, rdPtr;
    logic [ADDR_W+DATA_W-1:0] fifoMem [WFIFO_DEPTH];
    logic [MEM_LAT-1:0] rdPipe;
    logic fifoEmpty, fifoFull, pop, push, drop, issue;

    always_comb begin
        nextState = IDLE;
        runNext   = '0;
        fifoEmpty = (wfifo_level == '0);
        fifoFull  = (wfifo_level == LVL_W'(WFIFO_DEPTH));
        // An empty FIFO lifts the run cap so display fetch can stream freely.
        if (rd_req && ((runCnt < RUN_W'(MAX_RD_RUN)) || fifoEmpty)) begin
            nextState = RD;
            runNext   = (runCnt == RUN_W'(MAX_RD_RUN)) ? runCnt : runCnt + 1'b1;
        end else if (!fifoEmpty) begin
            nextState = WR;
        end
        pop   = (nextState == WR);
        push  = wr_valid && (!fifoFull || pop);
        drop  = wr_valid && fifoFull && !pop;
        issue = mem_en && !mem_we;
    end

    assign rd_gnt = (state == RD);

    always_ff @(posedge pixelClockX6) begin
        if (push) begin
            fifoMem[wrPtr] <= {wr_addr, wr_data};
        end
    end

    always_ff @(posedge pixelClockX6 or negedge nReset) begin
        if (!nReset) begin
            state         <= IDLE;
            runCnt        <= '0;
            wrPtr         <= '0;
            rdPtr         <= '0;
            wfifo_level   <= '0;
            mem_en        <= 1'b0;
            mem_we        <= 1'b0;
            mem_addr      <= '0;
            mem_wdata     <= '0;
            rdPipe        <= '0;
            rd_valid      <= 1'b0;
            rd_data       <= '0;
            wr_overflow   <= 1'b0;
            wr_drop_count <= '0;
        end else begin
            state  <= nextState;
            runCnt <= runNext;
            case (nextState)
                RD: begin
                    mem_en   <= 1'b1;
                    mem_we   <= 1'b0;
                    mem_addr <= rd_addr;
                end
                WR: begin
                    mem_en                <= 1'b1;
                    mem_we                <= 1'b1;
                    {mem_addr, mem_wdata} <= fifoMem[rdPtr];
                end
                default: mem_en <= 1'b0;
            endcase

            if (push) wrPtr <= wrPtr + 1'b1;
            if (pop)  rdPtr <= rdPtr + 1'b1;
            wfifo_level <= wfifo_level + LVL_W'(push) - LVL_W'(pop);

            // Read strobe travels MEM_LAT stages, then the data is captured.
            rdPipe   <= (rdPipe << 1) | MEM_LAT'(issue);
            rd_valid <= rdPipe[MEM_LAT-1];
            if (rdPipe[MEM_LAT-1]) rd_data <= mem_rdata;

            if (frame_start_flag) begin
                wr_overflow   <= drop;
                wr_drop_count <= {7'd0, drop};
            end else if (drop) begin
                wr_overflow <= 1'b1;
                if (wr_drop_count != 8'hFF) wr_drop_count <= wr_drop_count + 8'd1;
            end
        end
    end
endmodule

// File: doc/pi_framestore_arbiter.md
Name: pi_framestore_arbiter

Overview:
- Shares one single-port framestore memory between two requesters.
- Requester 1: Pi capture write stream, pixel writes addressed from the Pi line/dot/frame-line trackers.
- Requester 2: video-out read stream, real-time display fetch.
- Writes are buffered in a small FIFO. Reads have priority, limited by a run cap that guarantees write slots. Write overflow is detected and counted per frame.

Parameters:
- ADDR_W, 19, memory word address width (covers 720x576 pixels).
- DATA_W, 16, pixel word width.
- WFIFO_DEPTH, 4, write FIFO entries (power of 2, >=2).
- MEM_LAT, 2, memory read latency in clocks (>=1).
- MAX_RD_RUN, 4, max consecutive read grants before a pending write must be served.

Ports:
- pixelClockX6  in  1  system clock (6x pixel clock)
- nReset  in  1  asynchronous active-low reset
- frame_start_flag  in  1  one-cycle frame start pulse; clears overflow statistics
- wr_valid  in  1  one-cycle pixel write pulse
- wr_addr  in  ADDR_W  write address
- wr_data  in  DATA_W  write pixel
- rd_req  in  1  read request, held until rd_gnt
- rd_addr  in  ADDR_W  read address, stable while rd_req high
- rd_gnt  out  1  one-cycle read-issued pulse
- rd_valid  out  1  read data valid pulse
- rd_data  out  DATA_W  read data
- mem_en  out  1  memory access strobe
- mem_we  out  1  1 = write, 0 = read
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data
- wfifo_level  out  log2(WFIFO_DEPTH)+1  FIFO occupancy
- wr_overflow  out  1  sticky: a write was dropped this frame
- wr_drop_count  out  8  writes dropped this frame, saturates at 255

Behaviour:
- Reset values: all outputs 0, FIFO empty, run counter 0, read latency pipe cleared.
- Reset mid-operation: in-flight reads never produce rd_valid.
- At most one memory access per clock. mem_* outputs are registered.
- Decision in cycle N uses registered FIFO level, run counter, and live rd_req. The chosen access appears on mem_* in cycle N+1.
- States (last grant): IDLE, RD, WR.
- Grant rule, evaluated each cycle:
  - If rd_req=1 and (run<MAX_RD_RUN or FIFO empty): grant READ, run<=run+1 (saturating at MAX_RD_RUN).
  - Else if FIFO non-empty: grant WRITE, run<=0.
  - Else: IDLE, run<=0.
- READ grant:
  - Next cycle: mem_en=1, mem_we=0, mem_addr=rd_addr, rd_gnt=1.
  - rd_req still high during the rd_gnt cycle is a new request.
- WRITE grant:
  - Next cycle: mem_en=1, mem_we=1, mem_addr/mem_wdata = FIFO head.
  - The pop occurs at the granting edge.
- IDLE: mem_en=0. mem_we, mem_addr and mem_wdata hold their last values.
- Read return:
  - Read issued (mem_en=1, mem_we=0) in cycle M: mem_rdata is sampled in cycle M+MAX_LAT... specifically in cycle M+MEM_LAT.
  - rd_valid=1 and rd_data=captured value in cycle M+MEM_LAT+1.
  - Back-to-back reads return back-to-back, in order.
  - rd_data holds its value when rd_valid=0.
- FIFO:
  - Push on wr_valid.
  - Push and pop in the same cycle are both honoured; level unchanged.
  - Push while level==WFIFO_DEPTH with no pop in that cycle: data dropped, wr_overflow<=1, wr_drop_count increments (saturating).
  - Pointers wrap modulo WFIFO_DEPTH.
- frame_start_flag=1: wr_overflow<=0 and wr_drop_count<=0, unless a drop occurs in the same cycle, in which case wr_overflow<=1 and wr_drop_count<=1. FIFO contents are unaffected.
- rd_req with an empty FIFO is never capped, so continuous reads are allowed.

Test Plan:
- Reset, then a single wr_valid (addr 0x00010, data 0xABCD) with no reads -> mem_en=1, mem_we=1, addr 0x00010, data 0xABCD exactly two cycles after the push; wfifo_level returns to 0.
- Single rd_req at addr 0x12345, mem_rdata driven 0x5A5A at latency 2 -> rd_gnt and read strobe in the cycle after request; rd_valid with 0x5A5A three cycles after rd_gnt.
- rd_req held continuously plus 3 queued writes -> grant pattern R,R,R,R,W,R,R,R,R,W,R,R,R,R,W; all writes appear in push order.
- rd_req held continuously, FIFO empty -> rd_gnt every cycle for 20 cycles; 20 rd_valid pulses in order.
- Fill FIFO to 4 under read starvation, then 3 more wr_valid while reads are granted -> wr_overflow=1, wr_drop_count=3 (counting only pushes in cycles with no pop); next frame_start_flag clears both to 0.
- Assert nReset mid-stream with 2 reads in flight and FIFO level 3 -> all outputs 0 immediately; no rd_valid after release; wfifo_level=0.
